usart_rx_fifo: RTL
==================

# usart_rx_fifo

Receive-side byte buffer placed directly downstream of the USART receiver. It captures each byte the receiver completes and stores it in a first-word-fall-through FIFO. It presents the bytes to the consumer through a valid/ready handshake. It also tracks how many complete lines are buffered, where a line is ended by a configurable terminator byte, and it flags bytes dropped because the buffer was full.

## Interface
- ADDR_BIT, 4: FIFO address width; depth DEPTH = 2**ADDR_BIT (16 entries).
- TERM_CHAR, 8'h0A: line-terminator byte value.
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  byte from receiver; sampled only when rx_valid=1.
- rx_valid  input  1  single-cycle strobe: rx_data holds a newly completed byte (receiver's response pulse).
- out_data  output  8  byte at FIFO head; don't-care when out_valid=0.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head byte when out_valid & out_ready.
- count  output  ADDR_BIT+1  bytes currently stored, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- line_count  output  ADDR_BIT+1  terminator bytes currently stored.
- line_avail  output  1  line_count != 0.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.
- clear_ovf  input  1  clears overflow.

## Operation
- Storage: DEPTH x 8 memory; wr_ptr and rd_ptr are ADDR_BIT wide and wrap modulo DEPTH; count register is ADDR_BIT+1 wide.
- push_req = rx_valid. pop = out_valid & out_ready.
- push = push_req & (~full | pop):
  - When full, a byte is accepted only in the same cycle as a pop.
  - On push: mem[wr_ptr] <= rx_data, wr_ptr++.
- On pop: rd_ptr++.
- count update: +1 on push only; -1 on pop only; unchanged on both or neither.
- Drop: push_req & full & ~pop. The byte is discarded, pointers and count are unchanged, and overflow <= 1.
- overflow clearing:
  - clear_ovf=1 clears overflow.
  - If a drop occurs in the same cycle as clear_ovf, overflow ends at 1 (set wins).
- Line tracking:
  - push_term = push & (rx_data == TERM_CHAR).
  - pop_term = pop & (out_data == TERM_CHAR).
  - line_count: +1 on push_term only, -1 on pop_term only, else unchanged.
  - Invariant: line_count <= count.
- Pop on empty: impossible, because out_valid=0 when empty.
- A push into an empty FIFO is not poppable in the same cycle.
- Reset:
  - Clears pointers, count, line_count and overflow.
  - Memory contents are not cleared.
  - Reset mid-operation discards all buffered bytes.
  - An rx_valid coincident with reset is ignored.

## Timing
- All outputs are registered or derived from registers only; no combinational path from rx_valid or out_ready to any output.
- Reset values: out_valid=0, count=0, full=0, empty=1, line_count=0, line_avail=0, overflow=0. out_data is undefined until the first push.
- Write latency: a byte strobed at edge N is visible at out_data/out_valid after edge N, i.e. usable in cycle N+1.
- Head advance: a pop at edge N presents the next byte (or out_valid=0) after edge N.
- Throughput: one push and one pop per cycle sustained.
- count, full, empty, line_count and line_avail update at the same edge as the push or pop that changes them.
- overflow rises at the edge following the dropped strobe. It clears at the edge on which clear_ovf is sampled.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 on three consecutive cycles with out_ready=0:
  - count=3, out_data=0x41, out_valid=1, empty=0.
  - Then hold out_ready=1 for 3 cycles: consumer sees 0x41, 0x42, 0x43 in order; empty=1 and count=0 afterwards.
- Push 16 bytes 0x00..0x0F with out_ready=0:
  - full=1, count=16.
  - Push 0xAA: dropped, overflow=1, count=16.
  - Drain: bytes read 0x00..0x0F; 0xAA never appears.
  - Pulse clear_ovf: overflow=0 next cycle.
- FIFO full, push 0x55 in the same cycle as a pop:
  - Push is accepted, count stays 16, overflow stays 0.
  - 0x55 is the last byte drained.
- Push "H","i",0x0A,"A",0x0A:
  - line_count=2, line_avail=1.
  - Pop 3 bytes: line_count=1.
  - Pop 2 more: line_count=0, line_avail=0.
- Wrap-around: run 40 push/pop pairs with random occupancy 0..16 and compare against a reference queue. Every byte must match, and count/full/empty must be consistent each cycle.
- Reset asserted with count=5, line_count=2 and rx_valid=1 in the same cycle:
  - Next cycle count=0, line_count=0, out_valid=0, overflow=0.
  - The coincident byte is not stored.

Source files
------------

// File: rtl/usart_rx_fifo.sv
// Receive-side FWFT byte FIFO behind the USART receiver, with line
// (terminator) counting and a sticky overflow flag for dropped bytes.
module usart_rx_fifo #(
    parameter int         ADDR_BIT  = 4,
    parameter logic [7:0] TERM_CHAR = 8'h0A
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [7:0]          out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_BIT:0]   count,
    output logic                full,
    output logic                empty,
    output logic [ADDR_BIT:0]   line_count,
    output logic                line_avail,
    output logic                overflow,
    input  logic                clear_ovf
);
    localparam int                DEPTH   = 2 ** ADDR_BIT;
    localparam logic [ADDR_BIT:0] DEPTH_C = {1'b1, {ADDR_BIT{1'b0}}};
    localparam logic [ADDR_BIT:0] CNT_ONE = {{ADDR_BIT{1'b0}}, 1'b1};
    localparam logic [ADDR_BIT-1:0] PTR_ONE = {{(ADDR_BIT-1){1'b0}}, 1'b1};

    logic [7:0]          mem_q [DEPTH];
    logic [ADDR_BIT-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BIT-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BIT:0]   count_q, count_d;
    logic [ADDR_BIT:0]   line_q, line_d;
    logic                ovf_q, ovf_d;

    logic push, pop, drop, push_term, pop_term;

    assign out_data   = mem_q[rd_ptr_q];
    assign out_valid  = (count_q != '0);
    assign count      = count_q;
    assign full       = (count_q == DEPTH_C);
    assign empty      = (count_q == '0);
    assign line_count = line_q;
    assign line_avail = (line_q != '0);
    assign overflow   = ovf_q;

    // When full, a byte only fits if the head leaves in the same cycle.
    assign pop       = out_valid & out_ready;
    assign push      = rx_valid & (~full | pop);
    assign drop      = rx_valid & full & ~pop;
    assign push_term = push & (rx_data == TERM_CHAR);
    assign pop_term  = pop & (out_data == TERM_CHAR);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        line_d   = line_q;
        ovf_d    = ovf_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        case ({push_term, pop_term})
            2'b10:   line_d = line_q + CNT_ONE;
            2'b01:   line_d = line_q - CNT_ONE;
            default: line_d = line_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop)           ovf_d = 1'b1;
        else if (clear_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            line_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            line_q   <= line_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[wr_ptr_q] <= rx_data;
    end
endmodule
